// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl - central stall/flush controller for the 5-stage MIPS pipeline.
//
// Merges the stage stall requests into a per-stage hold vector, converts a
// MEM-stage exception into a flush lasting FLUSH_CYCLES cycles together with
// a redirect PC, and raises a sticky flag when stall requests persist for
// MAX_STALL consecutive cycles.
//
// Optional build macro: PIPE_CTRL_PERF_EN
//   defined   -> perf_stall_cycles_o / perf_flush_cnt_o are live 32-bit counters
//   undefined -> both ports are tied to zero (no counter flops)
//
// Handshake: there is no valid/ready pairing here. stall_o is a level that
// consumers sample every cycle; flush_o is a level, and new_pc_o is only
// meaningful while flush_o is high.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   stallreq_id_i        load-use hazard stall request from ID
//   stallreq_exe_i       multi-cycle busy from EXE
//   stallreq_mem_i       data-bus wait from MEM
//   exception_type_i     MEM-stage exception code (0 = none, 0xE = ERET)
//   cp0_epc_i            current EPC from CP0
//   stall_o[5:0]         hold per stage: [0]pc [1]if [2]id [3]exe [4]mem [5]wb
//   flush_o              clear all pipeline registers
//   new_pc_o             redirect target, valid while flush_o=1
//   stall_timeout_o      sticky watchdog flag, cleared only by rst
//   perf_stall_cycles_o  cycles with any stage held
//   perf_flush_cnt_o     number of RUN->FLUSH transitions
//   fsm_state            debug view of the controller state (0=RUN, 1=FLUSH)
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MAX_STALL    = 64,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id_i,
    input  logic        stallreq_exe_i,
    input  logic        stallreq_mem_i,
    input  logic [31:0] exception_type_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        stall_timeout_o,
    output logic [31:0] perf_stall_cycles_o,
    output logic [31:0] perf_flush_cnt_o,
    output logic        fsm_state
);

    localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] WD_MAX     = 16'(MAX_STALL);
    localparam logic [31:0] EXC_ERET   = 32'h0000000E;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [2:0]  flush_cnt, flush_cnt_next;
    logic [31:0] new_pc_next;
    logic [15:0] wd_cnt, wd_next;
    logic        timeout_next;
    logic        req_any;
    logic [5:0]  stall_req;

    assign req_any   = stallreq_id_i | stallreq_exe_i | stallreq_mem_i;
    assign flush_o   = (state == FLUSH);
    assign fsm_state = state;

    // The stalled stage and everything upstream of it are held; the stage
    // just downstream receives a bubble.
    always_comb begin
        stall_req = 6'b000000;
        if (stallreq_mem_i)      stall_req = 6'b011111;
        else if (stallreq_exe_i) stall_req = 6'b001111;
        else if (stallreq_id_i)  stall_req = 6'b000111;
    end

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        new_pc_next    = new_pc_o;
        wd_next        = wd_cnt;
        stall_o        = 6'b000000;

        case (state)
            RUN: begin
                // Requests still drive the stall vector in the detect cycle;
                // the flush takes over from the following cycle.
                stall_o = stall_req;
                if (exception_type_i != 32'h0) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                    new_pc_next    = (exception_type_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
                    wd_next        = 16'h0;
                end else if (req_any) begin
                    wd_next = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 16'd1;
                end else begin
                    wd_next = 16'h0;
                end
            end
            FLUSH: begin
                // Flush overrides stall; exceptions arriving now are dropped.
                wd_next = 16'h0;
                if (flush_cnt == 3'd0) state_next = RUN;
                else                   flush_cnt_next = flush_cnt - 3'd1;
            end
            default: state_next = RUN;
        endcase

        // Looking at the next count makes the flag visible the cycle after
        // the watchdog count reaches its limit.
        timeout_next = stall_timeout_o | (wd_next == WD_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RUN;
            flush_cnt       <= 3'd0;
            new_pc_o        <= 32'h0;
            wd_cnt          <= 16'h0;
            stall_timeout_o <= 1'b0;
        end else begin
            state           <= state_next;
            flush_cnt       <= flush_cnt_next;
            new_pc_o        <= new_pc_next;
            wd_cnt          <= wd_next;
            stall_timeout_o <= timeout_next;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles_o <= 32'h0;
            perf_flush_cnt_o    <= 32'h0;
        end else begin
            if (stall_o != 6'b000000)
                perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
            if (state == RUN && state_next == FLUSH)
                perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
        end
    end
`else
    assign perf_stall_cycles_o = 32'h0;
    assign perf_flush_cnt_o    = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl - directed bench for pipe_ctrl.
//
// Two instances share every input: u_a (FLUSH_CYCLES=1, MAX_STALL=4) and
// u_b (FLUSH_CYCLES=3, MAX_STALL=64). Inputs change 1 time unit after the
// rising edge and outputs are sampled 1 time unit later, away from the edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_id = 1'b0, req_exe = 1'b0, req_mem = 1'b0;
    logic [31:0] exc = 32'h0;
    logic [31:0] epc = 32'h0;

    logic [5:0]  a_stall, b_stall;
    logic        a_flush, b_flush;
    logic [31:0] a_new_pc, b_new_pc;
    logic        a_timeout, b_timeout;
    logic [31:0] a_perf_stall, b_perf_stall;
    logic [31:0] a_perf_flush, b_perf_flush;
    logic        a_state, b_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYCLES(1), .MAX_STALL(4), .EXC_VECTOR(32'hBFC00380)) u_a (
        .clk(clk), .rst(rst),
        .stallreq_id_i(req_id), .stallreq_exe_i(req_exe), .stallreq_mem_i(req_mem),
        .exception_type_i(exc), .cp0_epc_i(epc),
        .stall_o(a_stall), .flush_o(a_flush), .new_pc_o(a_new_pc),
        .stall_timeout_o(a_timeout),
        .perf_stall_cycles_o(a_perf_stall), .perf_flush_cnt_o(a_perf_flush),
        .fsm_state(a_state)
    );

    pipe_ctrl #(.FLUSH_CYCLES(3), .MAX_STALL(64), .EXC_VECTOR(32'hBFC00380)) u_b (
        .clk(clk), .rst(rst),
        .stallreq_id_i(req_id), .stallreq_exe_i(req_exe), .stallreq_mem_i(req_mem),
        .exception_type_i(exc), .cp0_epc_i(epc),
        .stall_o(b_stall), .flush_o(b_flush), .new_pc_o(b_new_pc),
        .stall_timeout_o(b_timeout),
        .perf_stall_cycles_o(b_perf_stall), .perf_flush_cnt_o(b_perf_flush),
        .fsm_state(b_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_id  = 1'b0;
        req_exe = 1'b0;
        req_mem = 1'b0;
        exc     = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic settle();
        idle_inputs();
        repeat (5) tick();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if (a_stall !== 6'b0 || b_stall !== 6'b0) begin
            n_fail++; $display("FAIL reset_stall got a=%b b=%b exp 000000", a_stall, b_stall);
        end
        n_tests++;
        if (a_flush !== 1'b0 || b_flush !== 1'b0 || a_state !== 1'b0) begin
            n_fail++; $display("FAIL reset_flush got a=%b b=%b state=%b exp 0", a_flush, b_flush, a_state);
        end
        n_tests++;
        if (a_new_pc !== 32'h0 || b_new_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_new_pc got a=%h b=%h exp 0", a_new_pc, b_new_pc);
        end
        n_tests++;
        if (a_timeout !== 1'b0 || a_perf_stall !== 32'h0 || a_perf_flush !== 32'h0) begin
            n_fail++; $display("FAIL reset_misc got to=%b ps=%0d pf=%0d exp 0", a_timeout, a_perf_stall, a_perf_flush);
        end
        tick();
    endtask

    task automatic test_stall_priority();
        // exe + id together for three cycles
        for (int i = 0; i < 3; i++) begin
            req_exe = 1'b1; req_id = 1'b1;
            #1;
            n_tests++;
            if (a_stall !== 6'b001111) begin
                n_fail++; $display("FAIL stall_exe_id cyc%0d got %b exp 001111", i, a_stall);
            end
            tick();
        end
        idle_inputs();
        #1;
        n_tests++;
        if (a_stall !== 6'b000000) begin
            n_fail++; $display("FAIL stall_release got %b exp 000000", a_stall);
        end
        tick();
        req_mem = 1'b1; req_exe = 1'b1; req_id = 1'b1;
        #1;
        n_tests++;
        if (a_stall !== 6'b011111) begin
            n_fail++; $display("FAIL stall_mem_prio got %b exp 011111", a_stall);
        end
        tick();
        idle_inputs();
        tick();
        req_id = 1'b1;
        #1;
        n_tests++;
        if (a_stall !== 6'b000111) begin
            n_fail++; $display("FAIL stall_id_only got %b exp 000111", a_stall);
        end
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (a_timeout !== 1'b0) begin
            n_fail++; $display("FAIL stall_no_timeout got %b exp 0", a_timeout);
        end
        tick();
    endtask

    task automatic test_exception();
        exc = 32'h8;
        #1;
        n_tests++;
        if (a_flush !== 1'b0 || a_stall !== 6'b0) begin
            n_fail++; $display("FAIL exc_detect got flush=%b stall=%b exp 0/000000", a_flush, a_stall);
        end
        tick();
        exc = 32'h0;
        #1;
        n_tests++;
        if (a_flush !== 1'b1 || a_new_pc !== 32'hBFC00380 || a_stall !== 6'b0 || a_state !== 1'b1) begin
            n_fail++; $display("FAIL exc_flush got flush=%b pc=%h stall=%b state=%b exp 1/bfc00380/000000/1",
                               a_flush, a_new_pc, a_stall, a_state);
        end
        tick();
        #1;
        n_tests++;
        if (a_flush !== 1'b0) begin
            n_fail++; $display("FAIL exc_flush_end got %b exp 0", a_flush);
        end
        settle();
    endtask

    task automatic test_eret_long_flush();
        req_mem = 1'b1;
        exc = 32'hE;
        epc = 32'h80001234;
        #1;
        n_tests++;
        if (b_stall !== 6'b011111 || b_flush !== 1'b0) begin
            n_fail++; $display("FAIL eret_detect got stall=%b flush=%b exp 011111/0", b_stall, b_flush);
        end
        tick();
        exc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (b_flush !== 1'b1 || b_new_pc !== 32'h80001234 || b_stall !== 6'b0) begin
                n_fail++; $display("FAIL eret_flush cyc%0d got flush=%b pc=%h stall=%b exp 1/80001234/000000",
                                   i, b_flush, b_new_pc, b_stall);
            end
            tick();
        end
        #1;
        n_tests++;
        if (b_flush !== 1'b0 || b_stall !== 6'b011111) begin
            n_fail++; $display("FAIL eret_after got flush=%b stall=%b exp 0/011111", b_flush, b_stall);
        end
        settle();
    endtask

    task automatic test_back_to_back();
        exc = 32'hE;
        epc = 32'h80000100;
        tick();
        // held exception while flushing must be ignored
        exc = 32'h5;
        epc = 32'h80000200;
        #1;
        n_tests++;
        if (a_flush !== 1'b1 || a_new_pc !== 32'h80000100) begin
            n_fail++; $display("FAIL b2b_first got flush=%b pc=%h exp 1/80000100", a_flush, a_new_pc);
        end
        tick();
        exc = 32'hA;
        #1;
        n_tests++;
        if (a_flush !== 1'b0) begin
            n_fail++; $display("FAIL b2b_gap got flush=%b exp 0", a_flush);
        end
        tick();
        exc = 32'h0;
        #1;
        n_tests++;
        if (a_flush !== 1'b1 || a_new_pc !== 32'hBFC00380) begin
            n_fail++; $display("FAIL b2b_second got flush=%b pc=%h exp 1/bfc00380", a_flush, a_new_pc);
        end
        tick();
        #1;
        n_tests++;
        if (a_flush !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end got flush=%b exp 0", a_flush);
        end
        settle();
    endtask

    task automatic test_watchdog();
        logic exp_to;
        do_reset();
        req_id = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            exp_to = (k >= 5);
            #1;
            n_tests++;
            if (a_timeout !== exp_to) begin
                n_fail++; $display("FAIL wd_cycle%0d got %b exp %b", k, a_timeout, exp_to);
            end
            tick();
        end
        idle_inputs();
        tick();
        #1;
        n_tests++;
        if (a_timeout !== 1'b1 || b_timeout !== 1'b0) begin
            n_fail++; $display("FAIL wd_sticky got a=%b b=%b exp 1/0", a_timeout, b_timeout);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if (a_timeout !== 1'b0) begin
            n_fail++; $display("FAIL wd_rst_clear got %b exp 0", a_timeout);
        end
        tick();
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        exc = 32'h9;
        tick();
        exc = 32'h0;
        #1;
        n_tests++;
        if (b_flush !== 1'b1) begin
            n_fail++; $display("FAIL rstf_first got flush=%b exp 1", b_flush);
        end
        tick();
        rst = 1'b1;
        #1;
        n_tests++;
        if (b_flush !== 1'b1) begin
            n_fail++; $display("FAIL rstf_sync got flush=%b exp 1", b_flush);
        end
        tick();
        #1;
        n_tests++;
        if (b_flush !== 1'b0 || b_new_pc !== 32'h0 || b_perf_flush !== 32'h0) begin
            n_fail++; $display("FAIL rstf_abort got flush=%b pc=%h pf=%0d exp 0/0/0", b_flush, b_new_pc, b_perf_flush);
        end
        rst = 1'b0;
        tick();
        #1;
        n_tests++;
        if (b_flush !== 1'b0) begin
            n_fail++; $display("FAIL rstf_stays got flush=%b exp 0", b_flush);
        end
        tick();
    endtask

    task automatic test_perf();
        do_reset();
        req_exe = 1'b1;
        repeat (3) tick();
        req_exe = 1'b0;
        exc = 32'h1;
        tick();
        settle();
        #1;
`ifdef PIPE_CTRL_PERF_EN
        n_tests++;
        if (a_perf_stall !== 32'd3 || a_perf_flush !== 32'd1) begin
            n_fail++; $display("FAIL perf_counts got ps=%0d pf=%0d exp 3/1", a_perf_stall, a_perf_flush);
        end
`else
        n_tests++;
        if (a_perf_stall !== 32'd0 || a_perf_flush !== 32'd0) begin
            n_fail++; $display("FAIL perf_tied got ps=%0d pf=%0d exp 0/0", a_perf_stall, a_perf_flush);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_stall_priority();
        test_exception();
        test_eret_long_flush();
        test_back_to_back();
        test_watchdog();
        test_reset_mid_flush();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage MIPS core; the producer end of the stall/flush interface consumed by every inter-stage register (pc, if2id, id2exe, exe2mem, mem2wb).
Merges stage stall requests into a per-stage stall vector and turns MEM-stage exceptions into a timed flush with a redirect PC.
Also watches for stuck stalls.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles flush_o stays high per exception (1..7)
MAX_STALL, 64, consecutive stall-request cycles before stall_timeout_o sets (2..65535)
EXC_VECTOR, 32'hBFC00380, redirect PC for every exception except ERET

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stallreq_id_i  in  1  load-use hazard stall request from ID
stallreq_exe_i  in  1  multi-cycle (mult/div) busy from EXE
stallreq_mem_i  in  1  data-bus wait from MEM
exception_type_i  in  32  MEM-stage exception code, 0 = none
cp0_epc_i  in  32  current EPC from CP0
stall_o  out  6  [0]pc [1]if [2]id [3]exe [4]mem [5]wb; 1 = hold
flush_o  out  1  clear all pipeline registers
new_pc_o  out  32  redirect target, valid while flush_o=1
stall_timeout_o  out  1  sticky watchdog flag
perf_stall_cycles_o  out  32  stall-cycle counter (optional feature)
perf_flush_cnt_o  out  32  flush-event counter (optional feature)

Behaviour:
- Reset: stall_o=0, flush_o=0, new_pc_o=0, stall_timeout_o=0, perf counters=0, FSM=RUN, watchdog count=0. Reset mid-flush aborts the flush immediately.
- stall_o is combinational from the requests. Priority is mem > exe > id:
  - mem request -> 6'b011111
  - exe request -> 6'b001111
  - id request -> 6'b000111
  - none -> 0
- Consumers insert a bubble at stage k+1 when stall_o[k]=1 and stall_o[k+1]=0.
- FSM RUN:
  - Exception detected when exception_type_i != 0.
  - Next cycle: state=FLUSH, flush_o=1, new_pc_o latched, flush counter loaded with FLUSH_CYCLES-1.
  - stall_o is driven normally during the detect cycle.
- new_pc_o selection:
  - cp0_epc_i when exception_type_i == 32'h0000000E (ERET).
  - EXC_VECTOR for every other nonzero code (1 int, 4 AdEL, 5 AdES, 8 sys, 9 bp, A RI, C ov, D tr).
- FSM FLUSH:
  - flush_o=1 and new_pc_o is held stable.
  - stall_o is forced to 0, because flush overrides stall.
  - exception_type_i is ignored.
  - The counter decrements each cycle; at 0 the next state is RUN and flush_o=0 that same next cycle.
  - Total flush_o high time is exactly FLUSH_CYCLES cycles.
- Back-to-back: an exception present in the first RUN cycle after FLUSH is accepted normally, so flush_o drops for exactly one cycle.
- Watchdog:
  - A 16-bit count increments each cycle any stallreq is high, counting in RUN only.
  - It clears on a cycle with no request or on entering FLUSH.
  - It saturates at MAX_STALL.
  - stall_timeout_o sets the cycle after the count reaches MAX_STALL and stays set until rst.
- Simultaneous exception and stall request in RUN: stall_o follows the requests that cycle; the flush wins from the next cycle.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined:
  - perf_stall_cycles_o increments every cycle stall_o != 0.
  - perf_flush_cnt_o increments once per RUN->FLUSH transition.
  - Both are 32-bit, wrap modulo 2^32, and clear on rst.
- Undefined: both ports are tied to 32'h0 and no counter flops are inferred.

Test Plan:
1. stallreq_exe_i=1 and stallreq_id_i=1 together for 3 cycles -> stall_o=6'b001111 for each of those cycles, then 0; stall_timeout_o stays 0.
2. exception_type_i=32'h8 for one cycle with FLUSH_CYCLES=1 -> next cycle flush_o=1, new_pc_o=32'hBFC00380, stall_o=0; the cycle after, flush_o=0.
3. exception_type_i=32'hE, cp0_epc_i=32'h80001234, FLUSH_CYCLES=3, stallreq_mem_i=1 throughout -> flush_o high for exactly 3 cycles with new_pc_o=32'h80001234 and stall_o=0; afterwards stall_o=6'b011111.
4. Second exception held during FLUSH, then code 32'hA presented in the first RUN cycle -> only that later one triggers a second flush; flush_o pattern is 1,0,1.
5. stallreq_id_i held with MAX_STALL=4 -> stall_timeout_o rises on cycle 5 and stays 1 after the request drops; rst clears it.
6. rst asserted in the second cycle of a 3-cycle flush -> next cycle flush_o=0 and new_pc_o=0; with PIPE_CTRL_PERF_EN, perf_flush_cnt_o=0.
